// File: rtl/scale_pkg.sv
// Shared types and defaults for the scale-mode controller and its address pipeline.
package scale_pkg;

  typedef enum logic [1:0] {
    SCALE_1X   = 2'b00,
    SCALE_RSVD = 2'b01,
    SCALE_4X2  = 2'b10,
    SCALE_2X2  = 2'b11
  } scale_mode_t;

  typedef enum logic {
    StIdle,
    StPending
  } ctrl_state_t;

  localparam int unsigned FB_WIDTH_DEFAULT  = 240;
  localparam int unsigned FB_HEIGHT_DEFAULT = 320;
  localparam int unsigned ADDR_W_DEFAULT    = 17;

  // Button cycle order: 1x -> 4x2 -> 2x2 -> 1x. The reserved mode never commits,
  // so it only falls back to 1x for completeness.
  function automatic scale_mode_t next_mode(input scale_mode_t mode);
    scale_mode_t nxt;
    unique case (mode)
      SCALE_1X:  nxt = SCALE_4X2;
      SCALE_4X2: nxt = SCALE_2X2;
      SCALE_2X2: nxt = SCALE_1X;
      default:   nxt = SCALE_1X;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/scale_addr_pipe.sv
// Two-stage coordinate-to-framebuffer-address pipeline.
// Stage 1 applies the mode table (scaled coords + on-image flag), stage 2 does the
// row-stride multiply-add. Video counts travel alongside so downstream muxing stays aligned.
module scale_addr_pipe
  import scale_pkg::*;
#(
  parameter int unsigned FB_WIDTH  = FB_WIDTH_DEFAULT,
  parameter int unsigned FB_HEIGHT = FB_HEIGHT_DEFAULT,
  parameter int unsigned ADDR_W    = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode,
  input  logic [10:0]       hcount,
  input  logic [9:0]        vcount,
  output logic [ADDR_W-1:0] addr,
  output logic              addr_valid,
  output logic [10:0]       hcount_dly,
  output logic [9:0]        vcount_dly
);

  logic [10:0]       sh_d, sh1_q;
  logic [9:0]        sv_d, sv1_q;
  logic              valid_d, valid1_q;
  logic [10:0]       h1_q;
  logic [9:0]        v1_q;

  logic [ADDR_W-1:0] addr_d, addr2_q;
  logic              valid2_q;
  logic [10:0]       h2_q;
  logic [9:0]        v2_q;

  // Stage 1 combinational: mode table lookup on the incoming coordinates.
  always_comb begin
    sh_d    = '0;
    sv_d    = '0;
    valid_d = 1'b0;
    unique case (scale_mode_t'(mode))
      SCALE_1X: begin
        sh_d    = hcount;
        sv_d    = vcount;
        valid_d = (32'(hcount) < FB_WIDTH) && (32'(vcount) < FB_HEIGHT);
      end
      SCALE_4X2: begin
        sh_d    = {2'b00, hcount[10:2]};
        sv_d    = {1'b0, vcount[9:1]};
        valid_d = (32'(hcount) < 4 * FB_WIDTH) && (32'(vcount) < 2 * FB_HEIGHT);
      end
      SCALE_2X2: begin
        sh_d    = {1'b0, hcount[10:1]};
        sv_d    = {1'b0, vcount[9:1]};
        valid_d = (32'(hcount) < 2 * FB_WIDTH) && (32'(vcount) < 2 * FB_HEIGHT);
      end
      default: begin
        // Reserved mode: nothing is on-image.
        valid_d = 1'b0;
      end
    endcase
  end

  // Stage 2 combinational: row-major address, forced to zero for off-image pixels.
  always_comb begin
    addr_d = '0;
    if (valid1_q) begin
      addr_d = ADDR_W'(sv1_q) * ADDR_W'(FB_WIDTH) + ADDR_W'(sh1_q);
    end
  end

  // Stage 1 registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh1_q    <= '0;
      sv1_q    <= '0;
      valid1_q <= 1'b0;
      h1_q     <= '0;
      v1_q     <= '0;
    end else begin
      sh1_q    <= sh_d;
      sv1_q    <= sv_d;
      valid1_q <= valid_d;
      h1_q     <= hcount;
      v1_q     <= vcount;
    end
  end

  // Stage 2 registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr2_q  <= '0;
      valid2_q <= 1'b0;
      h2_q     <= '0;
      v2_q     <= '0;
    end else begin
      addr2_q  <= addr_d;
      valid2_q <= valid1_q;
      h2_q     <= h1_q;
      v2_q     <= v1_q;
    end
  end

  assign addr       = addr2_q;
  assign addr_valid = valid2_q;
  assign hcount_dly = h2_q;
  assign vcount_dly = v2_q;

endmodule

// File: rtl/scale_ctrl.sv
// Frame-synchronous scale-mode controller. Requests (handshake or button) are latched
// and only committed on new_frame_in, so a frame is never drawn with mixed scaling.
// Also owns the framebuffer read-address pipeline driven by the committed mode.
module scale_ctrl
  import scale_pkg::*;
#(
  parameter int unsigned FB_WIDTH  = FB_WIDTH_DEFAULT,
  parameter int unsigned FB_HEIGHT = FB_HEIGHT_DEFAULT,
  parameter int unsigned ADDR_W    = ADDR_W_DEFAULT
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [10:0]       hcount_in,
  input  logic [9:0]        vcount_in,
  input  logic              new_frame_in,
  input  logic              req_valid_in,
  input  logic [1:0]        req_scale_in,
  output logic              req_ready_out,
  input  logic              btn_cycle_in,
  output logic [1:0]        scale_out,
  output logic              pending_out,
  output logic              err_out,
  output logic [ADDR_W-1:0] addr_out,
  output logic              addr_valid_out,
  output logic [10:0]       hcount_out,
  output logic [9:0]        vcount_out
);

  ctrl_state_t state_q, state_d;
  scale_mode_t scale_q, scale_d;
  scale_mode_t latch_q, latch_d;
  logic        err_q, err_d;
  logic        btn_q;
  logic        btn_rise;
  scale_mode_t req_mode;

  assign btn_rise = btn_cycle_in & ~btn_q;
  assign req_mode = scale_mode_t'(req_scale_in);

  // Next-state logic: accept in idle, commit on the frame boundary while pending.
  always_comb begin
    state_d = state_q;
    scale_d = scale_q;
    latch_d = latch_q;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        // The handshake has priority; a simultaneous button edge is dropped.
        if (req_valid_in) begin
          if (req_mode == SCALE_RSVD) begin
            err_d = 1'b1;
          end else begin
            latch_d = req_mode;
            state_d = StPending;
          end
        end else if (btn_rise) begin
          latch_d = next_mode(scale_q);
          state_d = StPending;
        end
      end
      StPending: begin
        if (new_frame_in) begin
          scale_d = latch_q;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Control state, committed mode, error pulse and button history.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= StIdle;
      scale_q <= SCALE_1X;
      latch_q <= SCALE_1X;
      err_q   <= 1'b0;
      btn_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      scale_q <= scale_d;
      latch_q <= latch_d;
      err_q   <= err_d;
      btn_q   <= btn_cycle_in;
    end
  end

  assign req_ready_out = (state_q == StIdle);
  assign pending_out   = (state_q == StPending);
  assign err_out       = err_q;
  assign scale_out     = scale_q;

  scale_addr_pipe #(
    .FB_WIDTH  (FB_WIDTH),
    .FB_HEIGHT (FB_HEIGHT),
    .ADDR_W    (ADDR_W)
  ) u_addr_pipe (
    .clk        (clk_in),
    .rst        (rst_in),
    .mode       (scale_q),
    .hcount     (hcount_in),
    .vcount     (vcount_in),
    .addr       (addr_out),
    .addr_valid (addr_valid_out),
    .hcount_dly (hcount_out),
    .vcount_dly (vcount_out)
  );

endmodule

// File: tb/tb_scale_ctrl.sv
// Bench for scale_ctrl: a directed table of cycles with hand-derived expectations,
// then randomized traffic against a behavioural model built from the mode rules.
module tb_scale_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        new_frame;
  logic        req_valid;
  logic [1:0]  req_scale;
  logic        req_ready;
  logic        btn;
  logic [1:0]  scale;
  logic        pending;
  logic        err;
  logic [16:0] addr;
  logic        addr_valid;
  logic [10:0] hcount_d;
  logic [9:0]  vcount_d;

  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  scale_ctrl dut (
    .clk_in         (clk),
    .rst_in         (rst),
    .hcount_in      (hcount),
    .vcount_in      (vcount),
    .new_frame_in   (new_frame),
    .req_valid_in   (req_valid),
    .req_scale_in   (req_scale),
    .req_ready_out  (req_ready),
    .btn_cycle_in   (btn),
    .scale_out      (scale),
    .pending_out    (pending),
    .err_out        (err),
    .addr_out       (addr),
    .addr_valid_out (addr_valid),
    .hcount_out     (hcount_d),
    .vcount_out     (vcount_d)
  );

  typedef struct packed {
    logic        rst;
    logic [10:0] h;
    logic [9:0]  v;
    logic        nf;
    logic        rv;
    logic [1:0]  rs;
    logic        btn;
    logic        chkp;
    logic [1:0]  es;
    logic        ep;
    logic        ee;
    logic [16:0] ea;
    logic        ev;
    logic [10:0] eh;
    logic [9:0]  evv;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t row(input int r, input int h, input int v, input int nf,
                               input int rv, input int rs, input int b, input int chkp,
                               input int es, input int ep, input int ee, input int ea,
                               input int ev, input int eh, input int evv);
    vec_t x;
    x.rst = 1'(r);   x.h  = 11'(h);  x.v  = 10'(v);  x.nf = 1'(nf);
    x.rv  = 1'(rv);  x.rs = 2'(rs);  x.btn = 1'(b);  x.chkp = 1'(chkp);
    x.es  = 2'(es);  x.ep = 1'(ep);  x.ee = 1'(ee);  x.ea = 17'(ea);
    x.ev  = 1'(ev);  x.eh = 11'(eh); x.evv = 10'(evv);
    return x;
  endfunction

  // Behavioural model: committed/latched mode as plain ints, pipeline as two slots.
  typedef struct {
    int addr;
    bit valid;
    int h;
    int v;
  } pix_t;

  int   m_scale, m_latch;
  bit   m_pend, m_err, m_btn;
  pix_t p1, p2;

  function automatic pix_t pix(input int h, input int v, input int mode);
    pix_t p;
    int sh, sv, lim_h, lim_v;
    sh = 0; sv = 0; lim_h = 0; lim_v = 0;
    case (mode)
      0: begin sh = h;     sv = v;     lim_h = 240; lim_v = 320; end
      2: begin sh = h / 4; sv = v / 2; lim_h = 960; lim_v = 640; end
      3: begin sh = h / 2; sv = v / 2; lim_h = 480; lim_v = 640; end
      default: begin lim_h = 0; lim_v = 0; end
    endcase
    p.valid = (h < lim_h) && (v < lim_v);
    p.addr  = p.valid ? (sv * 240 + sh) % 131072 : 0;
    p.h     = h;
    p.v     = v;
    return p;
  endfunction

  task automatic model_step();
    bit rise;
    if (rst) begin
      m_scale = 0; m_latch = 0; m_pend = 0; m_err = 0; m_btn = 0;
      p1 = '{0, 0, 0, 0};
      p2 = '{0, 0, 0, 0};
    end else begin
      rise  = btn && !m_btn;
      p2    = p1;
      p1    = pix(int'(hcount), int'(vcount), m_scale);
      m_err = 0;
      if (!m_pend) begin
        if (req_valid) begin
          if (req_scale == 2'b01) m_err = 1;
          else begin m_latch = int'(req_scale); m_pend = 1; end
        end else if (rise) begin
          m_latch = (m_scale == 0) ? 2 : (m_scale == 2) ? 3 : 0;
          m_pend  = 1;
        end
      end else if (new_frame) begin
        m_scale = m_latch;
        m_pend  = 0;
      end
      m_btn = btn;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    if (act != exp) begin
      nmis++;
      $display("FAIL %s at vector %0d: got %0d, expected %0d", name, nvec, act, exp);
    end
  endtask

  // Inputs are applied mid-cycle; outputs are sampled 1 time unit after the edge.
  task automatic apply(input logic r, input int h, input int v, input logic nf,
                       input logic rv, input int rs, input logic b);
    rst = r; hcount = 11'(h); vcount = 10'(v); new_frame = nf;
    req_valid = rv; req_scale = 2'(rs); btn = b;
    @(posedge clk);
    model_step();
    #1;
    nvec++;
  endtask

  initial begin
    rst = 1'b1; hcount = '0; vcount = '0; new_frame = 1'b0;
    req_valid = 1'b0; req_scale = '0; btn = 1'b0;

    //           rst  h    v  nf rv rs b chkp  es ep ee  addr  ev  eh  ev
    tbl.push_back(row(1,   0,   0, 0, 0, 0, 0, 1,  0, 0, 0,     0, 0,   0,   0));
    tbl.push_back(row(0,  10,   3, 0, 0, 0, 0, 1,  0, 0, 0,     0, 0,   0,   0));
    tbl.push_back(row(0,  10,   3, 0, 0, 0, 0, 1,  0, 0, 0,   730, 1,  10,   3));
    tbl.push_back(row(0, 959, 639, 0, 1, 3, 0, 1,  0, 1, 0,   730, 1,  10,   3));
    tbl.push_back(row(0,   5,   5, 0, 0, 0, 0, 1,  0, 1, 0,     0, 0, 959, 639));
    tbl.push_back(row(0,   7,   2, 1, 0, 0, 0, 1,  3, 0, 0,  1205, 1,   5,   5));
    tbl.push_back(row(0,   0,   0, 0, 0, 0, 0, 1,  3, 0, 0,   487, 1,   7,   2));
    tbl.push_back(row(0,  20,   7, 0, 0, 0, 0, 1,  3, 0, 0,     0, 1,   0,   0));
    tbl.push_back(row(0,   0,   0, 0, 1, 2, 0, 1,  3, 1, 0,   730, 1,  20,   7));
    tbl.push_back(row(0,   0,   0, 1, 0, 0, 0, 1,  2, 0, 0,     0, 1,   0,   0));
    tbl.push_back(row(0, 959, 639, 0, 0, 0, 0, 1,  2, 0, 0,     0, 1,   0,   0));
    tbl.push_back(row(0, 960, 639, 0, 0, 0, 0, 1,  2, 0, 0, 76799, 1, 959, 639));
    tbl.push_back(row(0,   0,   0, 0, 1, 1, 0, 1,  2, 0, 1,     0, 0, 960, 639));
    tbl.push_back(row(0,   0,   0, 0, 0, 0, 0, 1,  2, 0, 0,     0, 1,   0,   0));
    // Button: edge latches, edge while pending ignored, held level is not an edge.
    tbl.push_back(row(0,   0,   0, 0, 0, 0, 1, 0,  2, 1, 0,     0, 0,   0,   0));
    tbl.push_back(row(0,   0,   0, 0, 0, 0, 0, 0,  2, 1, 0,     0, 0,   0,   0));
    tbl.push_back(row(0,   0,   0, 0, 0, 0, 1, 0,  2, 1, 0,     0, 0,   0,   0));
    tbl.push_back(row(0,   0,   0, 1, 0, 0, 1, 0,  3, 0, 0,     0, 0,   0,   0));
    tbl.push_back(row(0,   0,   0, 0, 0, 0, 0, 0,  3, 0, 0,     0, 0,   0,   0));
    // Request and button edge together: request mode (10) wins over button (00).
    tbl.push_back(row(0,   0,   0, 0, 1, 2, 1, 0,  3, 1, 0,     0, 0,   0,   0));
    tbl.push_back(row(0,   0,   0, 1, 0, 0, 0, 0,  2, 0, 0,     0, 0,   0,   0));
    // Reset while pending discards the latched mode.
    tbl.push_back(row(0,   0,   0, 0, 0, 0, 1, 0,  2, 1, 0,     0, 0,   0,   0));
    tbl.push_back(row(1,   0,   0, 0, 0, 0, 0, 1,  0, 0, 0,     0, 0,   0,   0));
    tbl.push_back(row(0,   0,   0, 1, 0, 0, 0, 0,  0, 0, 0,     0, 0,   0,   0));
    // Three button edges with frames between: 10, 11, 00.
    tbl.push_back(row(0,   0,   0, 0, 0, 0, 1, 0,  0, 1, 0,     0, 0,   0,   0));
    tbl.push_back(row(0,   0,   0, 1, 0, 0, 0, 0,  2, 0, 0,     0, 0,   0,   0));
    tbl.push_back(row(0,   0,   0, 0, 0, 0, 1, 0,  2, 1, 0,     0, 0,   0,   0));
    tbl.push_back(row(0,   0,   0, 1, 0, 0, 0, 0,  3, 0, 0,     0, 0,   0,   0));
    tbl.push_back(row(0,   0,   0, 0, 0, 0, 1, 0,  3, 1, 0,     0, 0,   0,   0));
    tbl.push_back(row(0,   0,   0, 1, 0, 0, 0, 0,  0, 0, 0,     0, 0,   0,   0));
    // Request accepted with new_frame commits only at the following frame.
    tbl.push_back(row(0,   0,   0, 1, 1, 3, 0, 0,  0, 1, 0,     0, 0,   0,   0));
    tbl.push_back(row(0,   0,   0, 0, 0, 0, 0, 0,  0, 1, 0,     0, 0,   0,   0));
    tbl.push_back(row(0,   0,   0, 1, 0, 0, 0, 0,  3, 0, 0,     0, 0,   0,   0));
    // Requests are not accepted while pending (no err, latched mode kept).
    tbl.push_back(row(0,   0,   0, 0, 1, 2, 0, 0,  3, 1, 0,     0, 0,   0,   0));
    tbl.push_back(row(0,   0,   0, 0, 1, 1, 0, 0,  3, 1, 0,     0, 0,   0,   0));
    tbl.push_back(row(0,   0,   0, 1, 0, 0, 0, 0,  2, 0, 0,     0, 0,   0,   0));

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].rst, int'(tbl[i].h), int'(tbl[i].v), tbl[i].nf, tbl[i].rv,
            int'(tbl[i].rs), tbl[i].btn);
      chk("scale", int'(scale), int'(tbl[i].es));
      chk("pending", int'(pending), int'(tbl[i].ep));
      chk("ready", int'(req_ready), int'(!tbl[i].ep));
      chk("err", int'(err), int'(tbl[i].ee));
      if (tbl[i].chkp) begin
        chk("addr", int'(addr), int'(tbl[i].ea));
        chk("addr_valid", int'(addr_valid), int'(tbl[i].ev));
        chk("hcount_out", int'(hcount_d), int'(tbl[i].eh));
        chk("vcount_out", int'(vcount_d), int'(tbl[i].evv));
      end
    end

    // Randomized traffic against the model.
    begin
      logic b = 1'b0;
      for (int n = 0; n < 3000; n++) begin
        if ($urandom_range(0, 9) == 0) b = ~b;
        apply(($urandom_range(0, 199) == 0),
              int'($urandom_range(0, 1100)), int'($urandom_range(0, 700)),
              ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0),
              int'($urandom_range(0, 3)), b);
        chk("rnd scale", int'(scale), m_scale);
        chk("rnd pending", int'(pending), int'(m_pend));
        chk("rnd ready", int'(req_ready), int'(!m_pend));
        chk("rnd err", int'(err), int'(m_err));
        chk("rnd addr", int'(addr), p2.addr);
        chk("rnd addr_valid", int'(addr_valid), int'(p2.valid));
        chk("rnd hcount_out", int'(hcount_d), p2.h);
        chk("rnd vcount_out", int'(vcount_d), p2.v);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
